// File: rtl/uart_tx_frame_serializer.sv
// rtl/uart_tx_frame_serializer.sv - frame-to-word serializer with one-frame hold buffer for a UART TX
module uart_tx_frame_serializer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         arst,
   input  logic                         up_valid,
   output logic                         up_ready,
   input  logic [DEPTH-1:0][WIDTH-1:0]  up_data,
   input  logic [LW-1:0]                up_len,
   input  logic                         up_msb_first,
   output logic                         down_valid,
   input  logic                         down_ready,
   output logic [WIDTH-1:0]             down_data,
   output logic                         down_last,
   output logic                         busy
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_SEND      = 2'd1,
      S_SEND_HELD = 2'd2
   } state_t;

   state_t                        r_state;
   state_t                        w_state_nxt;

   logic [DEPTH-1:0][WIDTH-1:0]   r_act_data;
   logic [LW-1:0]                 r_act_len;
   logic                          r_act_msb;
   logic [LW-1:0]                 r_idx;

   logic [DEPTH-1:0][WIDTH-1:0]   r_hold_data;
   logic [LW-1:0]                 r_hold_len;
   logic                          r_hold_msb;

   logic                          w_act;
   logic                          w_hold_valid;
   logic [LW-1:0]                 w_len_clamp;
   logic [LW-1:0]                 w_last_idx;
   logic [LW-1:0]                 w_sel;
   logic [WIDTH-1:0]              w_word;
   logic                          w_up_go;
   logic                          w_beat;
   logic                          w_last_beat;
   logic                          w_load_up_act;
   logic                          w_load_hold_act;
   logic                          w_load_hold;

   // Hold occupancy is encoded in the state, so it cannot disagree with it.
   assign w_act        = (r_state != S_IDLE);
   assign w_hold_valid = (r_state == S_SEND_HELD);

   assign w_len_clamp  = (up_len > LW'(DEPTH)) ? LW'(DEPTH) : up_len;
   assign up_ready     = ~w_hold_valid & ~arst;
   // Zero-length frames are handshaken but never routed anywhere.
   assign w_up_go      = up_valid & up_ready & (w_len_clamp != '0);

   assign w_last_idx   = r_act_len - LW'(1);
   assign w_sel        = r_act_msb ? (w_last_idx - r_idx) : r_idx;

   assign down_valid   = w_act;
   assign down_last    = w_act & (r_idx == w_last_idx);
   assign down_data    = w_act ? w_word : '0;
   assign busy         = w_act;

   assign w_beat       = w_act & down_ready;
   assign w_last_beat  = w_beat & down_last;

   // Word select mux over the active frame; bounded so a stale index reads zero.
   always_comb begin
      w_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_sel == LW'(i)) begin
            w_word = r_act_data[i];
         end
      end
   end

   // Next-state and routing decisions for accepted frames.
   always_comb begin
      w_state_nxt     = r_state;
      w_load_up_act   = 1'b0;
      w_load_hold_act = 1'b0;
      w_load_hold     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_up_go) begin
               w_state_nxt   = S_SEND;
               w_load_up_act = 1'b1;
            end
         end
         S_SEND: begin
            if (w_last_beat) begin
               if (w_up_go) begin
                  w_load_up_act = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else if (w_up_go) begin
               w_state_nxt = S_SEND_HELD;
               w_load_hold = 1'b1;
            end
         end
         S_SEND_HELD: begin
            if (w_last_beat) begin
               w_state_nxt     = S_SEND;
               w_load_hold_act = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Active/hold frame storage and word counter.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_act_data  <= '0;
         r_act_len   <= '0;
         r_act_msb   <= 1'b0;
         r_idx       <= '0;
         r_hold_data <= '0;
         r_hold_len  <= '0;
         r_hold_msb  <= 1'b0;
      end else begin
         if (w_load_hold) begin
            r_hold_data <= up_data;
            r_hold_len  <= w_len_clamp;
            r_hold_msb  <= up_msb_first;
         end
         if (w_load_up_act) begin
            r_act_data <= up_data;
            r_act_len  <= w_len_clamp;
            r_act_msb  <= up_msb_first;
            r_idx      <= '0;
         end else if (w_load_hold_act) begin
            r_act_data <= r_hold_data;
            r_act_len  <= r_hold_len;
            r_act_msb  <= r_hold_msb;
            r_idx      <= '0;
         end else if (w_last_beat) begin
            r_idx <= '0;
         end else if (w_beat) begin
            r_idx <= r_idx + LW'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// tb/tb_uart_tx_frame_serializer.sv - scoreboard bench for uart_tx_frame_serializer
module tb_uart_tx_frame_serializer;

   logic              clk;
   logic              arst;
   logic              up_valid;
   logic              up_ready;
   logic [3:0][7:0]   up_data;
   logic [2:0]        up_len;
   logic              up_msb_first;
   logic              down_valid;
   logic              down_ready;
   logic [7:0]        down_data;
   logic              down_last;
   logic              busy;

   logic [8:0]        exp_q[$];
   int                n_checks;
   int                n_fail;

   uart_tx_frame_serializer #(.WIDTH(8), .DEPTH(4)) dut (
      .clk          (clk),
      .arst         (arst),
      .up_valid     (up_valid),
      .up_ready     (up_ready),
      .up_data      (up_data),
      .up_len       (up_len),
      .up_msb_first (up_msb_first),
      .down_valid   (down_valid),
      .down_ready   (down_ready),
      .down_data    (down_data),
      .down_last    (down_last),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void push_exp(input logic [3:0][7:0] d, input int len, input bit msb);
      int l;
      l = (len > 4) ? 4 : len;
      for (int i = 0; i < l; i++) begin
         int k;
         k = msb ? (l - 1 - i) : i;
         exp_q.push_back({(i == l - 1) ? 1'b1 : 1'b0, d[k]});
      end
   endfunction

   task automatic send(input logic [3:0][7:0] d, input int len, input bit msb);
      int n;
      up_data      = d;
      up_len       = 3'(len);
      up_msb_first = msb;
      up_valid     = 1'b1;
      n = 0;
      @(negedge clk);
      while (!up_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!up_ready) chk("up_ready_timeout", 32'(up_ready), 32'd1);
      @(posedge clk);
      push_exp(d, len, msb);
      #1;
      up_valid     = 1'b0;
      up_data      = $urandom;
      up_len       = 3'($urandom);
      up_msb_first = 1'($urandom);
   endtask

   // Compare every presented word against the scoreboard head; retire it on a beat.
   always @(negedge clk) begin
      if (!arst && down_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word_queue_size", 32'(exp_q.size()), 32'd1);
         end else begin
            chk("down_data", 32'(down_data), 32'(exp_q[0][7:0]));
            chk("down_last", 32'(down_last), 32'(exp_q[0][8]));
            if (down_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pat[7];
      n_checks     = 0;
      n_fail       = 0;
      arst         = 1'b1;
      up_valid     = 1'b0;
      up_data      = '0;
      up_len       = '0;
      up_msb_first = 1'b0;
      down_ready   = 1'b0;
      pat          = '{1, 0, 0, 1, 1, 0, 1};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_down_valid", 32'(down_valid), 32'd0);
      chk("rst_down_data",  32'(down_data),  32'd0);
      chk("rst_down_last",  32'(down_last),  32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_up_ready",   32'(up_ready),   32'd0);
      arst = 1'b0;
      #1;
      chk("rel_up_ready",   32'(up_ready),   32'd1);

      // basic lsb-first frame
      down_ready = 1'b1;
      send({8'd4, 8'd3, 8'd2, 8'd1}, 4, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("basic_last_busy", 32'(busy), 32'd1);
      chk("basic_last_flag", 32'(down_last), 32'd1);
      @(posedge clk);
      #1;
      chk("basic_busy_fall", 32'(busy), 32'd0);
      chk("basic_q_empty", 32'(exp_q.size()), 32'd0);

      // msb-first short frame, slot 3 never emitted
      send({8'hAA, 8'd30, 8'd20, 8'd10}, 3, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("msb_idle", 32'(down_valid), 32'd0);
      chk("msb_q_empty", 32'(exp_q.size()), 32'd0);

      // back-to-back frames through the hold buffer
      send({8'd0, 8'd0, 8'd2, 8'd1}, 2, 1'b0);
      send({8'd0, 8'd7, 8'd6, 8'd5}, 3, 1'b0);
      chk("b2b_up_ready_low", 32'(up_ready), 32'd0);
      chk("b2b_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("b2b_no_bubble", 32'(down_valid), 32'd1);
         if (i == 0) chk("b2b_up_ready_back", 32'(up_ready), 32'd1);
      end
      @(posedge clk);
      #1;
      chk("b2b_idle", 32'(down_valid), 32'd0);
      chk("b2b_q_empty", 32'(exp_q.size()), 32'd0);

      // back-pressure
      down_ready = 1'b0;
      send({8'd44, 8'd33, 8'd22, 8'd11}, 4, 1'b0);
      for (int i = 0; i < 7; i++) begin
         down_ready = pat[i][0];
         @(posedge clk);
         #1;
      end
      chk("bp_q_empty", 32'(exp_q.size()), 32'd0);
      chk("bp_idle", 32'(down_valid), 32'd0);
      down_ready = 1'b1;

      // len 0: accepted, nothing emitted
      send({8'd9, 8'd9, 8'd9, 8'd9}, 0, 1'b0);
      chk("len0_up_ready", 32'(up_ready), 32'd1);
      chk("len0_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("len0_no_valid", 32'(down_valid), 32'd0);

      // len 7 clamps to 4
      send({8'hD4, 8'hC3, 8'hB2, 8'hA1}, 7, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("len7_idle", 32'(down_valid), 32'd0);
      chk("len7_q_empty", 32'(exp_q.size()), 32'd0);

      // len 1: single beat marked last
      send({8'h11, 8'h22, 8'h33, 8'h5A}, 1, 1'b1);
      chk("len1_valid", 32'(down_valid), 32'd1);
      chk("len1_last", 32'(down_last), 32'd1);
      @(posedge clk);
      #1;
      chk("len1_idle", 32'(down_valid), 32'd0);

      // reset mid-frame with a frame held
      send({8'h04, 8'h03, 8'h02, 8'h01}, 4, 1'b0);
      send({8'h08, 8'h07, 8'h06, 8'h05}, 4, 1'b0);
      @(posedge clk);
      #1;
      arst = 1'b1;
      #1;
      chk("arst_down_valid", 32'(down_valid), 32'd0);
      chk("arst_down_last",  32'(down_last),  32'd0);
      chk("arst_busy",       32'(busy),       32'd0);
      chk("arst_up_ready",   32'(up_ready),   32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      arst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_no_valid", 32'(down_valid), 32'd0);
      chk("post_rst_busy",     32'(busy),       32'd0);
      send({8'h9C, 8'h9B, 8'h9A, 8'h99}, 2, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_idle", 32'(down_valid), 32'd0);
      chk("final_q_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame_serializer.md
# uart_tx_frame_serializer

Parametrised successor of the UART TX word serializer. It accepts a parallel frame of up to DEPTH words over a valid/ready handshake, with a per-frame length and word order. It emits the frame one word per accepted downstream beat to the UART transmitter, marking the final word. A one-frame holding buffer lets the next frame be accepted during transmission, so consecutive frames stream with no bubble.

## Interface
- WIDTH, 8, bits per word
- DEPTH, 4, maximum words per frame (>= 2)
- LW, $clog2(DEPTH+1), width of length field
- clk  in  1  clock, all state on rising edge
- arst  in  1  asynchronous reset, active-high; one clock, reset asynchronous active-high
- up_valid  in  1  frame offered
- up_ready  out  1  frame can be accepted
- up_data  in  [DEPTH-1:0][WIDTH-1:0]  frame words, index 0 = first slot
- up_len  in  LW  number of valid words, 0..DEPTH; values > DEPTH clamp to DEPTH
- up_msb_first  in  1  0: emit slot 0 first; 1: emit slot len-1 first
- down_valid  out  1  word presented
- down_ready  in  1  transmitter accepts word
- down_data  out  WIDTH  current word
- down_last  out  1  current word is last of frame
- busy  out  1  active frame or held frame present

## Operation
- Storage: active frame register (data, len, mode, word counter idx), plus one hold frame register with hold_valid.
- up_ready = ~hold_valid, gated low while arst is high. An up handshake is up_valid & up_ready at a rising edge.
- Routing an accepted frame:
  - Len 0 is consumed and discarded. It produces no beats and changes no state.
  - Otherwise the frame loads into active if active is free next cycle: either no active frame, or its last word handshakes this edge, and in both cases hold is empty.
  - Otherwise it loads into hold.
- down_valid = active present.
- down_data:
  - mode 0: active_data[idx]
  - mode 1: active_data[len-1-idx]
- down_last = down_valid & (idx == len-1).
- Beat = down_valid & down_ready.
- On a beat:
  - Non-last beat: idx increments.
  - Last beat: idx resets to 0. Active reloads from hold if hold_valid, which clears hold_valid. Otherwise it loads a frame accepted the same edge. Otherwise active becomes empty.
- States: IDLE (no active), SEND (active, hold empty), SEND_HELD (active, hold full).
  - IDLE -> SEND on a non-zero-length up handshake.
  - SEND -> SEND_HELD on an up handshake without a last beat.
  - SEND_HELD -> SEND on a last beat, with hold moving to active.
  - SEND -> IDLE on a last beat with no up handshake.
- Order is strictly FIFO: a held frame is always transmitted before any later frame.
- busy = active present | hold_valid.

## Timing
- Reset values: down_valid 0, down_data 0, down_last 0, busy 0, up_ready 0 while arst is high and 1 after release. Internal idx and len clear to 0 and hold_valid to 0.
- arst asserted mid-frame aborts the active and held frames immediately. No partial frame resumes after release.
- Latency: a frame accepted at edge N presents its first word from edge N (down_valid high in the cycle after N).
- There is no combinational path up_* -> down_*. down_* depend on registers only.
- up_ready depends on registers only, not on down_ready.
- Throughput with down_ready held at 1:
  - len words in len cycles.
  - The next frame's first word appears the cycle after the last word, provided it was accepted before or at the last-beat edge.
- Back-pressure: while down_valid & ~down_ready, down_data and down_last hold stable.
- up_* inputs are sampled only at the handshake edge. They may change freely afterwards.
- A simultaneous last beat and up handshake with hold empty: the new frame goes straight to active and hold stays empty.
- A simultaneous last beat and up handshake with hold full cannot occur, because up_ready is 0.
- len = 1: down_last is high on the only word.

## Test plan
- Reset then basic frame:
  - Stimulus: up_data {4,3,2,1} (slot3..slot0), len 4, mode 0, down_ready=1.
  - Response: down_data 1,2,3,4 on consecutive cycles, down_last only on 4, busy falls the cycle after.
- MSB-first short frame:
  - Stimulus: slots {x,30,20,10}, len 3, mode 1.
  - Response: 30,20,10, last on 10. Slot 3 is never emitted.
- Back-to-back:
  - Stimulus: frame A {1,2} len 2 is accepted. Frame B {5,6,7} len 3 is offered during A.
  - Response: B goes to hold and up_ready drops to 0. Output is 1,2,5,6,7 with no idle cycle. down_last is on 2 and 7, and up_ready returns to 1 after the edge where 2 is accepted.
- Back-pressure:
  - Stimulus: len 4 frame with down_ready toggled 1,0,0,1,1,0,1.
  - Response: each word holds stable while stalled. Exactly 4 beats in order, last on the 4th.
- Boundaries:
  - Stimulus and response, len 0: accepted (up_ready=1) and produces no down_valid.
  - Stimulus and response, len 7 with DEPTH=4: clamps to 4 words.
  - Stimulus and response, len 1: a single beat with down_last=1.
- Reset mid-operation:
  - Stimulus: arst pulsed after word 2 of a 4-word frame, with another frame held.
  - Response: down_valid, down_last and busy go 0 asynchronously. No further output until a new frame is accepted, and that frame starts at its first word.
